// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read channel (AR + R) between the instruction cache (I) and
// the data cache (D). One requester owns the channel per burst, from arbitration
// until its rlast beat completes.
module axi_read_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_arvalid,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    input  logic [2:0]        i_arsize,
    input  logic [1:0]        i_arburst,
    output logic              i_arready,
    output logic              i_rvalid,
    output logic              i_rlast,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              i_rready,

    input  logic              d_arvalid,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [7:0]        d_arlen,
    input  logic [2:0]        d_arsize,
    input  logic [1:0]        d_arburst,
    output logic              d_arready,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_rready,

    output logic              m_axi_arvalid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    input  logic              m_axi_arready,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rlast,
    input  logic [DATA_W-1:0] m_axi_rdata,
    output logic              m_axi_rready,

    output logic              icache_reading,
    output logic              dcache_reading,
    output logic              prot_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      last_owner_q, last_owner_d;
    logic [8:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  len_q, len_d;
    logic        prot_err_q, prot_err_d;

    logic              own_arvalid;
    logic [ADDR_W-1:0] own_araddr;
    logic [7:0]        own_arlen;
    logic [2:0]        own_arsize;
    logic [1:0]        own_arburst;
    logic              own_rready;

    // Request fields of whichever cache currently owns the channel
    always_comb begin
        if (owner_q == OWN_D) begin
            own_arvalid = d_arvalid;
            own_araddr  = d_araddr;
            own_arlen   = d_arlen;
            own_arsize  = d_arsize;
            own_arburst = d_arburst;
            own_rready  = d_rready;
        end else begin
            own_arvalid = i_arvalid;
            own_araddr  = i_araddr;
            own_arlen   = i_arlen;
            own_arsize  = i_arsize;
            own_arburst = i_arburst;
            own_rready  = i_rready;
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            beat_cnt_q   <= 9'd0;
            len_q        <= 8'd0;
            prot_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            prot_err_q   <= prot_err_d;
        end
    end

    // Arbitration, channel steering and burst-length check
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        beat_cnt_d    = beat_cnt_q;
        len_d         = len_q;
        prot_err_d    = prot_err_q;

        i_arready     = 1'b0;
        i_rvalid      = 1'b0;
        i_rlast       = 1'b0;
        d_arready     = 1'b0;
        d_rvalid      = 1'b0;
        d_rlast       = 1'b0;
        i_rdata       = m_axi_rdata;
        d_rdata       = m_axi_rdata;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = 8'd0;
        m_axi_arsize  = 3'd0;
        m_axi_arburst = 2'd0;
        m_axi_rready  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_arvalid || d_arvalid) begin
                    state_d = ST_ADDR;
                    if (i_arvalid && d_arvalid) begin
                        if (FIXED_PRIO != 0) begin
                            owner_d = OWN_D;
                        end else begin
                            owner_d = (last_owner_q == OWN_I) ? OWN_D : OWN_I;
                        end
                    end else begin
                        owner_d = d_arvalid ? OWN_D : OWN_I;
                    end
                end
            end
            ST_ADDR: begin
                m_axi_arvalid = own_arvalid;
                m_axi_araddr  = own_araddr;
                m_axi_arlen   = own_arlen;
                m_axi_arsize  = own_arsize;
                m_axi_arburst = own_arburst;
                if (owner_q == OWN_D) begin
                    d_arready = m_axi_arready;
                end else begin
                    i_arready = m_axi_arready;
                end
                if (own_arvalid && m_axi_arready) begin
                    len_d      = own_arlen;
                    beat_cnt_d = 9'd0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready = own_rready;
                if (owner_q == OWN_D) begin
                    d_rvalid = m_axi_rvalid;
                    d_rlast  = m_axi_rlast;
                end else begin
                    i_rvalid = m_axi_rvalid;
                    i_rlast  = m_axi_rlast;
                end
                if (m_axi_rvalid && own_rready) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                    if (m_axi_rlast) begin
                        if ((beat_cnt_q + 9'd1) != ({1'b0, len_q} + 9'd1)) begin
                            prot_err_d = 1'b1;
                        end
                        last_owner_d = owner_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Ownership flags decoded from the registered state
    assign icache_reading = (state_q != ST_IDLE) && (owner_q == OWN_I);
    assign dcache_reading = (state_q != ST_IDLE) && (owner_q == OWN_D);
    assign prot_err       = prot_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: directed bursts against a small AXI
// read slave model, with expected AR requests and R beats queued in grant order.
module tb_axi_read_arbiter;

    localparam bit SRC_I = 1'b0;
    localparam bit SRC_D = 1'b1;

    typedef struct packed {
        logic        src;
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic clk, reset;

    logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
    logic [63:0] i_araddr, i_rdata;
    logic [7:0]  i_arlen;
    logic [2:0]  i_arsize;
    logic [1:0]  i_arburst;
    logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
    logic [63:0] d_araddr, d_rdata;
    logic [7:0]  d_arlen;
    logic [2:0]  d_arsize;
    logic [1:0]  d_arburst;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [63:0] m_axi_araddr, m_axi_rdata;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        icache_reading, dcache_reading, prot_err;

    logic        fp_i_arvalid, fp_i_arready, fp_i_rvalid, fp_i_rlast, fp_i_rready;
    logic [63:0] fp_i_rdata;
    logic        fp_d_arvalid, fp_d_arready, fp_d_rvalid, fp_d_rlast, fp_d_rready;
    logic [63:0] fp_d_rdata;
    logic        fp_m_arvalid, fp_m_arready, fp_m_rvalid, fp_m_rlast, fp_m_rready;
    logic [63:0] fp_m_araddr;
    logic [7:0]  fp_m_arlen;
    logic [2:0]  fp_m_arsize;
    logic [1:0]  fp_m_arburst;
    logic        fp_icache_reading, fp_dcache_reading, fp_prot_err;

    beat_t exp_q[$];
    ar_t   ar_q[$];
    int    vectors;
    int    fails;
    int    ar_delay;
    int    short_by;

    axi_read_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .i_rdata(i_rdata), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arburst(d_arburst), .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .d_rdata(d_rdata), .d_rready(d_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast), .m_axi_rdata(m_axi_rdata),
        .m_axi_rready(m_axi_rready),
        .icache_reading(icache_reading), .dcache_reading(dcache_reading), .prot_err(prot_err)
    );

    axi_read_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .i_arvalid(fp_i_arvalid), .i_araddr(64'h100), .i_arlen(8'd0), .i_arsize(3'd3),
        .i_arburst(2'd1), .i_arready(fp_i_arready), .i_rvalid(fp_i_rvalid), .i_rlast(fp_i_rlast),
        .i_rdata(fp_i_rdata), .i_rready(fp_i_rready),
        .d_arvalid(fp_d_arvalid), .d_araddr(64'h200), .d_arlen(8'd0), .d_arsize(3'd3),
        .d_arburst(2'd1), .d_arready(fp_d_arready), .d_rvalid(fp_d_rvalid), .d_rlast(fp_d_rlast),
        .d_rdata(fp_d_rdata), .d_rready(fp_d_rready),
        .m_axi_arvalid(fp_m_arvalid), .m_axi_araddr(fp_m_araddr), .m_axi_arlen(fp_m_arlen),
        .m_axi_arsize(fp_m_arsize), .m_axi_arburst(fp_m_arburst), .m_axi_arready(fp_m_arready),
        .m_axi_rvalid(fp_m_rvalid), .m_axi_rlast(fp_m_rlast), .m_axi_rdata(64'h0),
        .m_axi_rready(fp_m_rready),
        .icache_reading(fp_icache_reading), .dcache_reading(fp_dcache_reading),
        .prot_err(fp_prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_burst(input bit side, input logic [63:0] a, input logic [7:0] l,
                              input int nbeats);
        beat_t b;
        ar_t   r;
        r.addr = a;
        r.len  = l;
        ar_q.push_back(r);
        for (int k = 0; k < nbeats; k++) begin
            b.src  = side;
            b.data = a + 64'(8 * k);
            b.last = (k == nbeats - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic req(input bit side, input logic [63:0] a, input logic [7:0] l);
        if (side == SRC_D) begin
            d_arvalid = 1'b1; d_araddr = a; d_arlen = l; d_arsize = 3'd3; d_arburst = 2'd1;
        end else begin
            i_arvalid = 1'b1; i_araddr = a; i_arlen = l; i_arsize = 3'd3; i_arburst = 2'd1;
        end
    endtask

    task automatic chk_beat(input bit side, input logic [63:0] data, input logic last);
        beat_t e;
        if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
        end else begin
            e = exp_q.pop_front();
            check("beat_src", 64'(side), 64'(e.src));
            check("beat_data", data, e.data);
            check("beat_last", 64'(last), 64'(e.last));
        end
    endtask

    // Observes AR handshakes and forwarded R beats against the expectation queues
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (i_rvalid && i_rready) chk_beat(SRC_I, i_rdata, i_rlast);
            if (d_rvalid && d_rready) chk_beat(SRC_D, d_rdata, d_rlast);
            check("single_owner", 64'(icache_reading && dcache_reading), 64'd0);
            if (m_axi_arvalid) begin
                if (ar_q.size() == 0) begin
                    fail_now("unexpected_ar");
                end else begin
                    check("ar_addr", m_axi_araddr, ar_q[0].addr);
                    check("ar_len", 64'(m_axi_arlen), 64'(ar_q[0].len));
                    check("ar_size_burst", 64'({m_axi_arsize, m_axi_arburst}), 64'(5'b011_01));
                    if (m_axi_arready) void'(ar_q.pop_front());
                end
            end
        end
    endtask

    // AXI read slave: delayed arready, data = addr + 8*beat, optional early rlast
    task automatic slave_loop();
        logic        rs, arv, har, hr;
        logic [63:0] a, s_addr;
        logic [7:0]  l;
        logic        s_busy;
        int          s_wait, s_beat, s_last;
        s_busy = 1'b0; s_wait = 0; s_beat = 0; s_last = 0; s_addr = 64'd0;
        forever begin
            @(negedge clk);
            rs  = reset;
            arv = m_axi_arvalid;
            har = m_axi_arvalid && m_axi_arready;
            hr  = m_axi_rvalid && m_axi_rready;
            a   = m_axi_araddr;
            l   = m_axi_arlen;
            @(posedge clk);
            #1;
            if (rs) begin
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                m_axi_rdata = 64'd0; s_busy = 1'b0; s_wait = 0;
            end else if (!s_busy) begin
                if (har) begin
                    s_busy = 1'b1; s_addr = a; s_last = int'(l) - short_by; s_beat = 0; s_wait = 0;
                    m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = a;
                    m_axi_rlast = (s_last == 0);
                end else if (arv) begin
                    if (s_wait >= ar_delay) m_axi_arready = 1'b1;
                    else s_wait++;
                end else begin
                    s_wait = 0;
                    m_axi_arready = 1'b0;
                end
            end else if (hr) begin
                if (s_beat == s_last) begin
                    s_busy = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
                end else begin
                    s_beat++;
                    m_axi_rdata = s_addr + 64'(8 * s_beat);
                    m_axi_rlast = (s_beat == s_last);
                end
            end
        end
    endtask

    // Requesters drop arvalid after their AR handshake
    task automatic drop_loop();
        logic hi, hd;
        forever begin
            @(negedge clk);
            hi = i_arvalid && i_arready;
            hd = d_arvalid && d_arready;
            @(posedge clk);
            #1;
            if (hi) i_arvalid = 1'b0;
            if (hd) d_arvalid = 1'b0;
        end
    endtask

    // Runs until all queued traffic is done and the arbiter is idle again
    task automatic wait_done(input bit tog_d);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            if (tog_d) begin
                if (dcache_reading) seen = 1'b1;
                else if (seen && exp_q.size() != 0) check("dcache_reading_hold", 64'(dcache_reading), 64'd1);
            end
            if (exp_q.size() == 0 && ar_q.size() == 0 && !icache_reading && !dcache_reading &&
                !i_arvalid && !d_arvalid) break;
            @(posedge clk);
            #1;
            if (tog_d) d_rready = ~d_rready;
            n++;
        end
        if (n >= 400) fail_now("wait_done_timeout");
    endtask

    initial begin
        int n;
        int dcnt;
        vectors = 0; fails = 0; ar_delay = 0; short_by = 0;
        reset = 1'b1;
        i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_arsize = 0; i_arburst = 0; i_rready = 1;
        d_arvalid = 0; d_araddr = 0; d_arlen = 0; d_arsize = 0; d_arburst = 0; d_rready = 1;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rdata = 0;
        fp_i_arvalid = 0; fp_d_arvalid = 0; fp_i_rready = 0; fp_d_rready = 0;
        fp_m_arready = 0; fp_m_rvalid = 0; fp_m_rlast = 0;
        fork
            monitor_loop();
            slave_loop();
            drop_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_m_rready", 64'(m_axi_rready), 64'd0);
        check("rst_readings", 64'({icache_reading, dcache_reading}), 64'd0);
        check("rst_prot_err", 64'(prot_err), 64'd0);

        // Single I burst, one-cycle request-to-arvalid latency
        @(posedge clk); #1;
        push_burst(SRC_I, 64'h1000, 8'd7, 8);
        req(SRC_I, 64'h1000, 8'd7);
        @(negedge clk);
        check("lat_idle_arvalid", 64'(m_axi_arvalid), 64'd0);
        @(negedge clk);
        check("lat_arvalid", 64'(m_axi_arvalid), 64'd1);
        check("lat_icache_reading", 64'(icache_reading), 64'd1);
        wait_done(1'b0);
        check("single_prot_err", 64'(prot_err), 64'd0);

        // Tie: D wins (last owner I), then I; repeat with the same outcome
        @(posedge clk); #1;
        push_burst(SRC_D, 64'h2000, 8'd3, 4);
        push_burst(SRC_I, 64'h3000, 8'd1, 2);
        req(SRC_D, 64'h2000, 8'd3);
        req(SRC_I, 64'h3000, 8'd1);
        wait_done(1'b0);
        @(posedge clk); #1;
        push_burst(SRC_D, 64'h2100, 8'd0, 1);
        push_burst(SRC_I, 64'h3100, 8'd2, 3);
        req(SRC_D, 64'h2100, 8'd0);
        req(SRC_I, 64'h3100, 8'd2);
        wait_done(1'b0);
        check("tie_prot_err", 64'(prot_err), 64'd0);

        // D burst with slow arready and toggling rready
        @(posedge clk); #1;
        ar_delay = 5;
        push_burst(SRC_D, 64'h6000, 8'd5, 6);
        req(SRC_D, 64'h6000, 8'd5);
        wait_done(1'b1);
        @(posedge clk); #1;
        ar_delay = 0;
        d_rready = 1'b1;

        // Early rlast: arlen=3 but only 2 beats
        short_by = 2;
        push_burst(SRC_I, 64'h4000, 8'd3, 2);
        req(SRC_I, 64'h4000, 8'd3);
        wait_done(1'b0);
        check("short_prot_err", 64'(prot_err), 64'd1);
        @(posedge clk); #1;
        short_by = 0;
        push_burst(SRC_D, 64'h5000, 8'd1, 2);
        req(SRC_D, 64'h5000, 8'd1);
        wait_done(1'b0);
        check("sticky_prot_err", 64'(prot_err), 64'd1);

        // Reset in the middle of a 16-beat burst
        @(posedge clk); #1;
        push_burst(SRC_I, 64'h8000, 8'd15, 16);
        req(SRC_I, 64'h8000, 8'd15);
        n = 0;
        while (n < 100 && exp_q.size() > 13) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("midburst_timeout");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_i_rvalid", 64'({i_rvalid, i_rlast, i_arready}), 64'd0);
        check("mrst_d_rvalid", 64'({d_rvalid, d_rlast, d_arready}), 64'd0);
        check("mrst_m_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("mrst_m_rready", 64'(m_axi_rready), 64'd0);
        check("mrst_readings", 64'({icache_reading, dcache_reading}), 64'd0);
        check("mrst_prot_err", 64'(prot_err), 64'd0);
        exp_q.delete();
        ar_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        push_burst(SRC_I, 64'h9000, 8'd1, 2);
        req(SRC_I, 64'h9000, 8'd1);
        wait_done(1'b0);
        check("post_rst_prot_err", 64'(prot_err), 64'd0);

        // Fixed priority instance: stray rvalid ignored, then D starves I
        @(posedge clk); #1;
        fp_m_rvalid = 1'b1; fp_m_rlast = 1'b1;
        @(negedge clk);
        check("stray_rvalid", 64'({fp_i_rvalid, fp_d_rvalid, fp_m_rready}), 64'd0);
        @(posedge clk); #1;
        fp_i_arvalid = 1'b1; fp_d_arvalid = 1'b1; fp_m_arready = 1'b1;
        fp_i_rready = 1'b1; fp_d_rready = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("fp_i_starved", 64'(fp_icache_reading), 64'd0);
            if (fp_d_rvalid && fp_d_rlast) dcnt++;
        end
        check("fp_d_served", 64'(dcnt >= 10), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
